// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: decode feedback, instruction-memory handshake and IF/ID outputs.
// master = fetch unit side, slave = decode/memory side.
interface instruction_fetch_unit_if;
    logic        ID_stall;
    logic        ID_PCSrc;
    logic [31:0] ID_new_PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic [31:0] PC;

    modport master (
        input  ID_stall, ID_PCSrc, ID_new_PC, imem_ready, imem_rdata,
        output imem_req, imem_addr, IF_ID_Instruction, IF_ID_PC4, IF_ID_Valid, PC
    );

    modport slave (
        output ID_stall, ID_PCSrc, ID_new_PC, imem_ready, imem_rdata,
        input  imem_req, imem_addr, IF_ID_Instruction, IF_ID_PC4, IF_ID_Valid, PC
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch stage: owns the PC, issues single-outstanding imem requests
// and drives the IF/ID register, honouring stall and redirect from decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    instruction_fetch_unit_if.master    bus
);
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redirect;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc4;

    // Decode operands may be stale while stalled, so a stalled redirect is ignored.
    assign redirect = bus.ID_PCSrc & ~bus.ID_stall;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        hold_instr_d  = hold_instr_q;
        hold_pc4_d    = hold_pc4_q;
        deliver       = 1'b0;
        deliver_instr = NOP_WORD;
        deliver_pc4   = ifid_pc4_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                if (redirect) begin
                    pc_d   = bus.ID_new_PC;
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.imem_ready) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_ISSUE;
                        if (redirect) pc_d = bus.ID_new_PC;
                    end else if (!bus.ID_stall) begin
                        deliver       = 1'b1;
                        deliver_instr = bus.imem_rdata;
                        deliver_pc4   = pc_plus4;
                        pc_d          = pc_plus4;
                        state_d       = S_ISSUE;
                    end else begin
                        // PC stays put until the buffered word is handed to decode.
                        hold_instr_d = bus.imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = S_FULL;
                    end
                end else if (redirect) begin
                    pc_d   = bus.ID_new_PC;
                    kill_d = 1'b1;
                end
            end
            default: begin
                if (redirect) begin
                    pc_d    = bus.ID_new_PC;
                    state_d = S_ISSUE;
                end else if (!bus.ID_stall) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    deliver_pc4   = hold_pc4_q;
                    pc_d          = pc_plus4;
                    state_d       = S_ISSUE;
                end
            end
        endcase

        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (!bus.ID_stall) begin
            ifid_instr_d = deliver ? deliver_instr : NOP_WORD;
            ifid_pc4_d   = deliver_pc4;
            ifid_valid_d = deliver;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            hold_instr_q <= NOP_WORD;
            hold_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign bus.imem_req          = (state_q == S_ISSUE);
    assign bus.imem_addr         = pc_q;
    assign bus.PC                = pc_q;
    assign bus.IF_ID_Instruction = ifid_instr_q;
    assign bus.IF_ID_PC4         = ifid_pc4_q;
    assign bus.IF_ID_Valid       = ifid_valid_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a fixed-latency memory responder.
module tb_instruction_fetch_unit;
    logic Clk;
    logic Rst_n;
    int   errors;
    int   checks;

    instruction_fetch_unit_if ifc ();

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (ifc)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Memory responder: req seen in cycle c -> ready pulse in cycle c+lat.
    logic        resp_en;
    int          lat;
    logic        resp_ready, man_ready;
    logic [31:0] resp_rdata, man_rdata, raddr;

    assign ifc.imem_ready = resp_ready | man_ready;
    assign ifc.imem_rdata = man_ready ? man_rdata : resp_rdata;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0007;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    initial begin
        resp_ready = 1'b0;
        resp_rdata = 32'd0;
        forever begin
            @(negedge Clk);
            if (resp_en && Rst_n && ifc.imem_req) begin
                raddr = ifc.imem_addr;
                repeat (lat) @(posedge Clk);
                #1;
                resp_ready = 1'b1;
                resp_rdata = mem_word(raddr);
                @(posedge Clk);
                #1;
                resp_ready = 1'b0;
                resp_rdata = 32'd0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 (S_BOOT) after release.
    task automatic do_reset();
        Rst_n         = 1'b0;
        ifc.ID_stall  = 1'b0;
        ifc.ID_PCSrc  = 1'b0;
        ifc.ID_new_PC = 32'd0;
        man_ready     = 1'b0;
        man_rdata     = 32'd0;
        repeat (3) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n         = 1'b0;
        ifc.ID_stall  = 1'b0;
        ifc.ID_PCSrc  = 1'b0;
        ifc.ID_new_PC = 32'd0;
        #3;
        checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ifc.imem_req); end
        checks++; if (ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", ifc.imem_addr); end
        checks++; if (ifc.IF_ID_Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", ifc.IF_ID_Instruction); end
        checks++; if (ifc.IF_ID_PC4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 00000000", ifc.IF_ID_PC4); end
        checks++; if (ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.IF_ID_Valid); end
        checks++; if (ifc.PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", ifc.PC); end
    endtask

    task automatic test_basic_fetch();
        logic [5:0]  exp_req   = 6'b101010;   // bit i = cycle i
        logic [5:0]  exp_valid = 6'b101000;
        logic [31:0] exp_instr [6] = '{32'h0, 32'h0, 32'h0, 32'h2008_0005, 32'h0, 32'h2009_0007};
        logic [31:0] exp_pc4   [6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        logic [31:0] exp_addr  [6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        lat = 1; resp_en = 1'b1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            checks++; if (ifc.imem_req !== exp_req[c]) begin errors++; $display("FAIL basic_req c%0d: got %b want %b", c, ifc.imem_req, exp_req[c]); end
            checks++; if (ifc.IF_ID_Valid !== exp_valid[c]) begin errors++; $display("FAIL basic_valid c%0d: got %b want %b", c, ifc.IF_ID_Valid, exp_valid[c]); end
            checks++; if (ifc.IF_ID_Instruction !== exp_instr[c]) begin errors++; $display("FAIL basic_instr c%0d: got %h want %h", c, ifc.IF_ID_Instruction, exp_instr[c]); end
            checks++; if (ifc.IF_ID_PC4 !== exp_pc4[c]) begin errors++; $display("FAIL basic_pc4 c%0d: got %h want %h", c, ifc.IF_ID_PC4, exp_pc4[c]); end
            checks++; if (ifc.imem_addr !== exp_addr[c]) begin errors++; $display("FAIL basic_addr c%0d: got %h want %h", c, ifc.imem_addr, exp_addr[c]); end
            nxt();
        end
    endtask

    task automatic test_stall();
        lat = 1; resp_en = 1'b1;
        do_reset();
        repeat (3) nxt();
        ifc.ID_stall = 1'b1;                       // cycles 3..5
        @(negedge Clk);
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h4) begin errors++; $display("FAIL stall_issue c3: got req=%b addr=%h want req=1 addr=00000004", ifc.imem_req, ifc.imem_addr); end
        nxt();
        for (int c = 4; c < 7; c++) begin
            if (c == 6) ifc.ID_stall = 1'b0;
            @(negedge Clk);
            checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d: got %b want 0", c, ifc.imem_req); end
            checks++; if (ifc.IF_ID_Instruction !== 32'h2008_0005 || ifc.IF_ID_PC4 !== 32'h4 || ifc.IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL stall_hold c%0d: got %h/%h/%b want 20080005/00000004/1", c, ifc.IF_ID_Instruction, ifc.IF_ID_PC4, ifc.IF_ID_Valid); end
            checks++; if (ifc.PC !== 32'h4) begin errors++; $display("FAIL stall_pc c%0d: got %h want 00000004", c, ifc.PC); end
            nxt();
        end
        @(negedge Clk);
        checks++; if (ifc.IF_ID_Instruction !== 32'h2009_0007 || ifc.IF_ID_PC4 !== 32'h8 || ifc.IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL stall_release c7: got %h/%h/%b want 20090007/00000008/1", ifc.IF_ID_Instruction, ifc.IF_ID_PC4, ifc.IF_ID_Valid); end
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next_req c7: got req=%b addr=%h want req=1 addr=00000008", ifc.imem_req, ifc.imem_addr); end
        nxt();
        @(negedge Clk);
        checks++; if (ifc.PC !== 32'h8 || ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL stall_once c8: got pc=%h valid=%b want pc=00000008 valid=0", ifc.PC, ifc.IF_ID_Valid); end
        nxt();
    endtask

    task automatic test_redirect_wait();
        lat = 2; resp_en = 1'b1;
        do_reset();
        repeat (2) nxt();
        ifc.ID_PCSrc = 1'b1; ifc.ID_new_PC = 32'h40;   // cycle 2, still waiting
        nxt();
        ifc.ID_PCSrc = 1'b0; ifc.ID_new_PC = 32'h0;
        @(negedge Clk);
        checks++; if (ifc.PC !== 32'h40 || ifc.imem_req !== 1'b0 || ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL redir_c3: got pc=%h req=%b valid=%b want pc=00000040 req=0 valid=0", ifc.PC, ifc.imem_req, ifc.IF_ID_Valid); end
        nxt();
        @(negedge Clk);
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h40 || ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL redir_reissue c4: got req=%b addr=%h valid=%b want req=1 addr=00000040 valid=0", ifc.imem_req, ifc.imem_addr, ifc.IF_ID_Valid); end
        nxt();
        for (int c = 5; c < 7; c++) begin
            @(negedge Clk);
            checks++; if (ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL redir_bubble c%0d: got %b want 0", c, ifc.IF_ID_Valid); end
            nxt();
        end
        @(negedge Clk);
        checks++; if (ifc.IF_ID_Instruction !== 32'hA5A5_0040 || ifc.IF_ID_PC4 !== 32'h44 || ifc.IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL redir_target c7: got %h/%h/%b want a5a50040/00000044/1", ifc.IF_ID_Instruction, ifc.IF_ID_PC4, ifc.IF_ID_Valid); end
        nxt();
    endtask

    task automatic test_stall_redirect();
        lat = 1; resp_en = 1'b1;
        do_reset();
        repeat (2) nxt();
        ifc.ID_stall = 1'b1; ifc.ID_PCSrc = 1'b1; ifc.ID_new_PC = 32'h80;   // cycles 2,3
        nxt();
        @(negedge Clk);
        checks++; if (ifc.PC !== 32'h0 || ifc.imem_req !== 1'b0 || ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL stredir_ignored c3: got pc=%h req=%b valid=%b want pc=00000000 req=0 valid=0", ifc.PC, ifc.imem_req, ifc.IF_ID_Valid); end
        nxt();
        ifc.ID_stall = 1'b0;                                                // cycle 4: redirect taken
        @(negedge Clk);
        checks++; if (ifc.PC !== 32'h0 || ifc.imem_req !== 1'b0) begin errors++; $display("FAIL stredir_c4: got pc=%h req=%b want pc=00000000 req=0", ifc.PC, ifc.imem_req); end
        nxt();
        ifc.ID_PCSrc = 1'b0; ifc.ID_new_PC = 32'h0;
        @(negedge Clk);
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h80) begin errors++; $display("FAIL stredir_req c5: got req=%b addr=%h want req=1 addr=00000080", ifc.imem_req, ifc.imem_addr); end
        checks++; if (ifc.IF_ID_Valid !== 1'b0 || ifc.IF_ID_Instruction !== 32'h0) begin errors++; $display("FAIL stredir_squash c5: got %h/%b want 00000000/0", ifc.IF_ID_Instruction, ifc.IF_ID_Valid); end
        repeat (2) nxt();
        @(negedge Clk);
        checks++; if (ifc.IF_ID_Instruction !== 32'hA5A5_0080 || ifc.IF_ID_PC4 !== 32'h84 || ifc.IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL stredir_target c7: got %h/%h/%b want a5a50080/00000084/1", ifc.IF_ID_Instruction, ifc.IF_ID_PC4, ifc.IF_ID_Valid); end
        nxt();
    endtask

    task automatic test_wrap();
        lat = 1; resp_en = 1'b1;
        do_reset();
        nxt();
        ifc.ID_PCSrc = 1'b1; ifc.ID_new_PC = 32'hFFFF_FFFC;   // redirect during S_ISSUE
        @(negedge Clk);
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_issue c1: got req=%b addr=%h want req=1 addr=00000000", ifc.imem_req, ifc.imem_addr); end
        nxt();
        ifc.ID_PCSrc = 1'b0; ifc.ID_new_PC = 32'h0;
        @(negedge Clk);
        checks++; if (ifc.PC !== 32'hFFFF_FFFC || ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL wrap_kill c2: got pc=%h valid=%b want pc=fffffffc valid=0", ifc.PC, ifc.IF_ID_Valid); end
        nxt();
        @(negedge Clk);
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req c3: got req=%b addr=%h want req=1 addr=fffffffc", ifc.imem_req, ifc.imem_addr); end
        checks++; if (ifc.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL wrap_discard c3: got valid=%b want 0", ifc.IF_ID_Valid); end
        repeat (2) nxt();
        @(negedge Clk);
        checks++; if (ifc.IF_ID_Instruction !== 32'h5A5A_FFFC || ifc.IF_ID_PC4 !== 32'h0 || ifc.IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid c5: got %h/%h/%b want 5a5afffc/00000000/1", ifc.IF_ID_Instruction, ifc.IF_ID_PC4, ifc.IF_ID_Valid); end
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next c5: got req=%b addr=%h want req=1 addr=00000000", ifc.imem_req, ifc.imem_addr); end
        nxt();
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        do_reset();
        nxt();
        ifc.ID_PCSrc = 1'b1; ifc.ID_new_PC = 32'h100;
        nxt();
        ifc.ID_PCSrc = 1'b0; ifc.ID_new_PC = 32'h0;   // cycle 2, S_WAIT
        checks++; if (ifc.PC !== 32'h100) begin errors++; $display("FAIL rmid_pre: got pc=%h want 00000100", ifc.PC); end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++; if (ifc.PC !== 32'h0 || ifc.imem_addr !== 32'h0 || ifc.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_async: got pc=%h addr=%h req=%b want 00000000/00000000/0", ifc.PC, ifc.imem_addr, ifc.imem_req); end
        checks++; if (ifc.IF_ID_Valid !== 1'b0 || ifc.IF_ID_PC4 !== 32'h0) begin errors++; $display("FAIL rmid_ifid: got valid=%b pc4=%h want 0/00000000", ifc.IF_ID_Valid, ifc.IF_ID_PC4); end
        nxt();
        Rst_n = 1'b1;                                  // r0: stray response from old request
        man_ready = 1'b1; man_rdata = 32'hDEAD_BEEF;
        nxt();
        @(negedge Clk);
        checks++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_first_req r1: got req=%b addr=%h want req=1 addr=00000000", ifc.imem_req, ifc.imem_addr); end
        nxt();
        man_ready = 1'b1; man_rdata = 32'h2008_0005;   // r2: genuine response
        @(negedge Clk);
        checks++; if (ifc.IF_ID_Valid !== 1'b0 || ifc.IF_ID_Instruction !== 32'h0 || ifc.PC !== 32'h0) begin errors++; $display("FAIL rmid_stray r2: got %h/%b pc=%h want 00000000/0 pc=00000000", ifc.IF_ID_Instruction, ifc.IF_ID_Valid, ifc.PC); end
        nxt();
        man_ready = 1'b0; man_rdata = 32'h0;
        @(negedge Clk);
        checks++; if (ifc.IF_ID_Instruction !== 32'h2008_0005 || ifc.IF_ID_PC4 !== 32'h4 || ifc.IF_ID_Valid !== 1'b1 || ifc.PC !== 32'h4) begin errors++; $display("FAIL rmid_resume r3: got %h/%h/%b pc=%h want 20080005/00000004/1 pc=00000004", ifc.IF_ID_Instruction, ifc.IF_ID_PC4, ifc.IF_ID_Valid, ifc.PC); end
        nxt();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        resp_en   = 1'b0;
        lat       = 1;
        man_ready = 1'b0;
        man_rdata = 32'd0;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_stall_redirect();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
